// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester (cpu, dbg) arbiter driving a multiplexed
// 8-bit external bus. Each transaction runs IDLE -> ADDR_HI -> ADDR_LO ->
// DATA -> DONE, so the ack comes four cycles after the request is sampled.
//
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   - a tie in IDLE goes to the requester that was not granted
//               last (a last-grant register resets to dbg, so cpu wins the
//               first tie).
//   undefined - fixed priority, dbg always wins a tie.
//
// Handshake: a requester raises req with we/addr/wdata and holds them until
// its one-cycle ack. Everything is latched at grant, so later changes
// (including dropping req) are ignored until DONE. A req still high in the
// cycle after ack is a new request.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  output logic        dbg_ack,
  output logic [7:0]  dbg_rdata,
  output logic [7:0]  bus_out,
  output logic [7:0]  bus_oe,
  input  logic [7:0]  bus_in,
  output logic        bus_ale_hi,
  output logic        bus_ale_lo,
  output logic        bus_we,
  output logic        bus_re,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    DATA    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        we_q;
  logic        gnt_dbg_q;
  logic        grant_dbg;
  logic        any_req;

  assign any_req   = cpu_req | dbg_req;
  assign cpu_rdata = rdata_q;
  assign dbg_rdata = rdata_q;
  assign fsm_state = state;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_dbg_q;

  // Winner selection: on a tie the side that did not win last time gets it.
  always_comb begin
    grant_dbg = dbg_req & (~cpu_req | ~last_dbg_q);
  end

  // Remember which side won the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dbg_q <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_dbg_q <= grant_dbg;
    end
  end
`else
  // Winner selection: dbg takes every tie.
  always_comb begin
    grant_dbg = dbg_req;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winning request at grant; capture read data at the end of DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      gnt_dbg_q <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      if (state == IDLE && any_req) begin
        gnt_dbg_q <= grant_dbg;
        addr_q    <= grant_dbg ? dbg_addr  : cpu_addr;
        wdata_q   <= grant_dbg ? dbg_wdata : cpu_wdata;
        we_q      <= grant_dbg ? dbg_we    : cpu_we;
      end
      if (state == DATA && !we_q) begin
        rdata_q <= bus_in;
      end
    end
  end

  // Next-state and bus/ack outputs; everything idles low by default.
  always_comb begin
    state_next = state;
    bus_out    = 8'h00;
    bus_oe     = 8'h00;
    bus_ale_hi = 1'b0;
    bus_ale_lo = 1'b0;
    bus_we     = 1'b0;
    bus_re     = 1'b0;
    cpu_ack    = 1'b0;
    dbg_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = ADDR_HI;
      end
      ADDR_HI: begin
        bus_out    = addr_q[15:8];
        bus_oe     = 8'hFF;
        bus_ale_hi = 1'b1;
        state_next = ADDR_LO;
      end
      ADDR_LO: begin
        bus_out    = addr_q[7:0];
        bus_oe     = 8'hFF;
        bus_ale_lo = 1'b1;
        state_next = DATA;
      end
      DATA: begin
        if (we_q) begin
          bus_out = wdata_q;
          bus_oe  = 8'hFF;
          bus_we  = 1'b1;
        end else begin
          bus_re  = 1'b1;
        end
        state_next = DONE;
      end
      DONE: begin
        cpu_ack    = ~gnt_dbg_q;
        dbg_ack    = gnt_dbg_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written corner
// sequences (tie arbitration, reset mid-transaction, inputs changing after
// grant) and a randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] dbg_addr = 16'h0;
  logic [7:0]  dbg_wdata = 8'h0;
  logic [7:0]  bus_in = 8'h0;
  logic        cpu_ack, dbg_ack;
  logic [7:0]  cpu_rdata, dbg_rdata, bus_out, bus_oe;
  logic        bus_ale_hi, bus_ale_lo, bus_we, bus_re;
  logic [2:0]  fsm_state;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .bus_ale_hi(bus_ale_hi), .bus_ale_lo(bus_ale_lo), .bus_we(bus_we), .bus_re(bus_re),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output bundle: {bus_out, bus_oe, ale_hi, ale_lo, we, re, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata}
  function automatic logic [37:0] outs();
    return {bus_out, bus_oe, bus_ale_hi, bus_ale_lo, bus_we, bus_re,
            cpu_ack, dbg_ack, cpu_rdata, dbg_rdata};
  endfunction

  function automatic logic [37:0] e(input logic [7:0] bo, input logic [7:0] oe,
                                    input logic ah, input logic al, input logic w,
                                    input logic r, input logic ca, input logic da,
                                    input logic [7:0] rd);
    return {bo, oe, ah, al, w, r, ca, da, rd, rd};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_reqs();
    cpu_req = 1'b0; dbg_req = 1'b0;
    cpu_we = 1'b0;  dbg_we = 1'b0;
  endtask

  // Ends at a negedge with rst just released; that cycle is IDLE.
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [15:0] c_addr;
    logic [7:0]  c_wdata;
    logic [7:0]  b_in;
    logic [37:0] exp;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic rq, input logic we, input logic [15:0] a,
                              input logic [7:0] wd, input logic [7:0] bi,
                              input logic [37:0] ex);
    vec_t v;
    v.c_req = rq; v.c_we = we; v.c_addr = a; v.c_wdata = wd; v.b_in = bi; v.exp = ex;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Transaction-level view: a grant starts a 5-cycle transaction; m_age
  // counts cycles since the grant (0 = no transaction in flight).
  int          m_age;
  logic        m_dbg, m_we, m_last_dbg;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;

  function automatic logic [37:0] model_exp();
    case (m_age)
      1: return e(m_addr[15:8], 8'hFF, 1, 0, 0, 0, 0, 0, m_rdata);
      2: return e(m_addr[7:0],  8'hFF, 0, 1, 0, 0, 0, 0, m_rdata);
      3: return m_we ? e(m_wdata, 8'hFF, 0, 0, 1, 0, 0, 0, m_rdata)
                     : e(8'h00,   8'h00, 0, 0, 0, 1, 0, 0, m_rdata);
      4: return e(8'h00, 8'h00, 0, 0, 0, 0, !m_dbg, m_dbg, m_rdata);
      default: return e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, m_rdata);
    endcase
  endfunction

  // Advance the model across the next rising edge using the current inputs.
  task automatic model_step();
    logic pick_dbg;
    if (rst) begin
      m_age = 0; m_rdata = 8'h00; m_last_dbg = 1'b1;
    end else if (m_age == 0) begin
      if (cpu_req || dbg_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_dbg = (cpu_req && dbg_req) ? !m_last_dbg : dbg_req;
`else
        pick_dbg = dbg_req;
`endif
        m_dbg      = pick_dbg;
        m_addr     = pick_dbg ? dbg_addr  : cpu_addr;
        m_wdata    = pick_dbg ? dbg_wdata : cpu_wdata;
        m_we       = pick_dbg ? dbg_we    : cpu_we;
        m_last_dbg = pick_dbg;
        m_age      = 1;
      end
    end else begin
      if (m_age == 3 && !m_we) m_rdata = bus_in;
      m_age = (m_age + 1) % 5;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // cpu write A55A/3C, then cpu read 0102 returning E7.
    vecs[0]  = mk(1, 1, 16'hA55A, 8'h3C, 8'h00, e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs[1]  = mk(1, 1, 16'hA55A, 8'h3C, 8'h00, e(8'hA5, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs[2]  = mk(1, 1, 16'hA55A, 8'h3C, 8'h00, e(8'h5A, 8'hFF, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs[3]  = mk(1, 1, 16'hA55A, 8'h3C, 8'h00, e(8'h3C, 8'hFF, 0, 0, 1, 0, 0, 0, 8'h00));
    vecs[4]  = mk(0, 1, 16'hA55A, 8'h3C, 8'h00, e(8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00));
    vecs[5]  = mk(1, 0, 16'h0102, 8'h00, 8'h00, e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs[6]  = mk(1, 0, 16'h0102, 8'h00, 8'h00, e(8'h01, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs[7]  = mk(1, 0, 16'h0102, 8'h00, 8'h00, e(8'h02, 8'hFF, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs[8]  = mk(1, 0, 16'h0102, 8'h00, 8'hE7, e(8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00));
    vecs[9]  = mk(0, 0, 16'h0102, 8'h00, 8'h00, e(8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'hE7));
    vecs[10] = mk(0, 0, 16'h0102, 8'h00, 8'h00, e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'hE7));

    clear_reqs();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      cpu_req = vecs[i].c_req; cpu_we = vecs[i].c_we;
      cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wdata;
      bus_in = vecs[i].b_in;
      #1 chk($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, vecs[i].exp});
    end

    // Reset in DATA of a write: transaction dropped, rdata cleared.
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h55;
    step(); step(); step();
    #1 chk("rst_pre_data", {26'd0, outs()}, {26'd0, e(8'h55, 8'hFF, 0, 0, 1, 0, 0, 0, 8'hE7)});
    rst = 1'b1;
    step();
    cpu_req = 1'b0;
    #1 chk("rst_idle", {26'd0, outs()}, {26'd0, e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00)});
    step(); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1 chk($sformatf("rst_noack%0d", c), {26'd0, outs()},
             {26'd0, e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00)});
      step();
    end

    // dbg write C3D4/81; dbg_req dropped in ADDR_LO, addresses changed later.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'hC3D4; dbg_wdata = 8'h81;
    step();
    #1 chk("late_hi", {26'd0, outs()}, {26'd0, e(8'hC3, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00)});
    step();
    dbg_req = 1'b0; dbg_addr = 16'hFFFF; dbg_wdata = 8'h00;
    #1 chk("late_lo", {26'd0, outs()}, {26'd0, e(8'hD4, 8'hFF, 0, 1, 0, 0, 0, 0, 8'h00)});
    step();
    cpu_addr = 16'hBEEF;
    #1 chk("late_data", {26'd0, outs()}, {26'd0, e(8'h81, 8'hFF, 0, 0, 1, 0, 0, 0, 8'h00)});
    step();
    #1 chk("late_ack", {26'd0, outs()}, {26'd0, e(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 8'h00)});
    step();
    #1 chk("late_idle", {26'd0, outs()}, {26'd0, e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00)});

    // Both requesters held from reset: grant order by build.
    cpu_req = 1'b1; cpu_we = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      logic [1:0] exp_ack;
      exp_ack = 2'b00;
      if (c % 5 == 4) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_ack = ((c / 5) % 2 == 0) ? 2'b10 : 2'b01;
`else
        exp_ack = 2'b01;
`endif
      end
      bus_in = 8'($urandom_range(0, 255));
      #1 chk($sformatf("tie_c%0d", c), {62'd0, cpu_ack, dbg_ack}, {62'd0, exp_ack});
      step();
    end

    // Randomized run against the reference model.
    clear_reqs();
    do_reset();
    m_age = 0; m_rdata = 8'h00; m_last_dbg = 1'b1;
    m_dbg = 1'b0; m_we = 1'b0; m_addr = 16'h0; m_wdata = 8'h0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) step();
      rst       = ($urandom_range(0, 99) == 0);
      cpu_req   = ($urandom_range(0, 2) != 0);
      dbg_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = 1'($urandom_range(0, 1));
      dbg_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom_range(0, 65535));
      dbg_addr  = 16'($urandom_range(0, 65535));
      cpu_wdata = 8'($urandom_range(0, 255));
      dbg_wdata = 8'($urandom_range(0, 255));
      bus_in    = 8'($urandom_range(0, 255));
      #1 chk("rand", {26'd0, outs()}, {26'd0, model_exp()});
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
